// File: rtl/lsu_pkg.sv
// Package for the load/store unit.
// Holds the RV32I load/store funct3 encodings, the LSU state enum, the memory
// command codes issued on rmem/wmem, and a helper giving the access size.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [4:0] RMEM_WORD = 5'b01111;
    localparam logic [3:0] WMEM_WORD = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_WR0  = 3'd3,
        S_WR1  = 3'd4,
        S_RESP = 3'd5
    } lsu_state_t;

    // Access size in bytes, decoded from funct3[1:0] (B=1, H=2, W=4).
    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte alignment datapath for the load/store unit (purely combinational).
// Works on the 64-bit window {buf1, buf0} of the word(s) touched by the access.
// Ports:
//   funct3  in  3   access type (size and signedness)
//   off     in  2   byte offset within the first word
//   wdata   in  32  store data, right-justified
//   buf0    in  32  first word read from memory
//   buf1    in  32  second word read from memory (0 when not spanning)
//   merged  out 64  read-modify-write result, {high word, low word}
//   rdata   out 32  extracted and extended load data
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] buf0,
    input  logic [31:0] buf1,
    output logic [63:0] merged,
    output logic [31:0] rdata
);

    logic [3:0]  base_m;
    logic [7:0]  lane_m;
    logic [63:0] old_w;
    logic [63:0] data_w;
    logic [31:0] sh;

    always_comb begin
        case (funct3[1:0])
            2'b00:   base_m = 4'b0001;
            2'b01:   base_m = 4'b0011;
            default: base_m = 4'b1111;
        endcase
        old_w  = {buf1, buf0};
        lane_m = {4'b0000, base_m} << off;
        data_w = {32'h0, wdata} << {off, 3'b000};
        // Byte-granular merge: only the lanes covered by the access change.
        for (int i = 0; i < 8; i++) begin
            merged[8*i +: 8] = lane_m[i] ? data_w[8*i +: 8] : old_w[8*i +: 8];
        end
        sh = 32'(old_w >> {off, 3'b000});
        case (funct3)
            F3_B:    rdata = {{24{sh[7]}}, sh[7:0]};
            F3_H:    rdata = {{16{sh[15]}}, sh[15:0]};
            F3_W:    rdata = sh;
            F3_BU:   rdata = {24'h0, sh[7:0]};
            F3_HU:   rdata = {16'h0, sh[15:0]};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: drives the data port of the unified memory for one
// load/store request at a time. Memory reads are combinational, writes land on
// the clock edge. Every store is a full-word read-modify-write.
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned accesses over
// two words; otherwise misaligned accesses complete with resp_err and no
// memory traffic.
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only while idle, and request inputs are ignored otherwise.
// resp_valid is a single-cycle pulse with no back-pressure.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_funct3       store flag and RV32I funct3
//   req_addr, req_wdata      byte address, store data
//   resp_valid/rdata/err     completion pulse, load data, error flag
//   wmem, rmem, mem_addr     memory command and word index
//   store_data, load_data    memory write word / read word
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  wmem,
    output logic [4:0]  rmem,
    output logic [31:0] mem_addr,
    output logic [31:0] store_data,
    input  logic [31:0] load_data
);

    lsu_state_t state, state_n;

    logic [ADDR_W+1:0] addr_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [31:0]       wd_q;
    logic              err_q;
    logic              span_q;
    logic [31:0]       buf0, buf1;

    logic              accept;
    logic              illegal;
    logic              bad_in;
    logic              span_in;
    logic [ADDR_W-1:0] w_lo, w_hi;
    logic [63:0]       merged;
    logic [31:0]       ld_rdata;

    // Address bits above the memory's word range play no part in the access.
    logic unused_hi_addr;
    assign unused_hi_addr = ^req_addr[31:ADDR_W+2];

    assign accept  = req_valid && (state == S_IDLE);
    assign illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Misaligned accesses are legal; they need a second word when the bytes
    // run past the end of the first one.
    assign bad_in  = illegal;
    assign span_in = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3)) > 3'd4;
`else
    logic misal;
    assign misal   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign bad_in  = illegal || misal;
    assign span_in = 1'b0;
`endif

    assign w_lo = addr_q[ADDR_W+1:2];
    assign w_hi = w_lo + {{(ADDR_W-1){1'b0}}, 1'b1};  // wraps mod 2**ADDR_W

    lsu_align u_align (
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .wdata  (wd_q),
        .buf0   (buf0),
        .buf1   (buf1),
        .merged (merged),
        .rdata  (ld_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            addr_q <= '0;
            f3_q   <= 3'b000;
            we_q   <= 1'b0;
            wd_q   <= 32'h0;
            err_q  <= 1'b0;
            span_q <= 1'b0;
            buf0   <= 32'h0;
            buf1   <= 32'h0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q <= req_addr[ADDR_W+1:0];
                f3_q   <= req_funct3;
                we_q   <= req_we;
                wd_q   <= req_wdata;
                err_q  <= bad_in;
                span_q <= span_in;
                buf0   <= 32'h0;
                buf1   <= 32'h0;
            end
            if (state == S_RD0) buf0 <= load_data;
            if (state == S_RD1) buf1 <= load_data;
        end
    end

    always_comb begin
        state_n    = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;
        wmem       = 4'b0000;
        rmem       = 5'b00000;
        mem_addr   = 32'h0;
        store_data = 32'h0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = bad_in ? S_RESP : S_RD0;
            end
            S_RD0: begin
                rmem     = RMEM_WORD;
                mem_addr = {{(32-ADDR_W){1'b0}}, w_lo};
                if (span_q)    state_n = S_RD1;
                else if (we_q) state_n = S_WR0;
                else           state_n = S_RESP;
            end
            S_RD1: begin
                rmem     = RMEM_WORD;
                mem_addr = {{(32-ADDR_W){1'b0}}, w_hi};
                state_n  = we_q ? S_WR0 : S_RESP;
            end
            S_WR0: begin
                wmem       = WMEM_WORD;
                mem_addr   = {{(32-ADDR_W){1'b0}}, w_lo};
                store_data = merged[31:0];
                state_n    = span_q ? S_WR1 : S_RESP;
            end
            S_WR1: begin
                wmem       = WMEM_WORD;
                mem_addr   = {{(32-ADDR_W){1'b0}}, w_hi};
                store_data = merged[63:32];
                state_n    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? 32'h0 : ld_rdata;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
